odd_parity_serial_rx: RTL
=========================

// Module: odd_parity_serial_rx
// PURPOSE
//  Bit-serial receiver feeding the 9-bit odd-parity checker. Deserialises frames
//  of start(0), DATA_BITS data bits (LSB first), one odd-parity bit and stop(1).
//  Presents {parity,data} as one parallel word with a valid/ready handshake.
//  Does NOT judge parity; the downstream checker does. Framing/overrun flagged here.
// PARAMETERS
//  CLKS_PER_BIT  16  clk cycles per serial bit; legal >= 4, even
//  DATA_BITS      8  data bits per frame; frame word width N = DATA_BITS+1 (9)
// PORTS
//  clk          in   1  rising-edge clock
//  rst          in   1  asynchronous, active-high reset
//  serial_in    in   1  asynchronous serial line, idles high
//  data_out     out  N  {parity bit, data[DATA_BITS-1:0]}; bit N-1 = parity
//  data_valid   out  1  data_out holds an unconsumed frame
//  data_ready   in   1  consumer accepts data_out when data_valid&&data_ready
//  framing_err  out  1  1-cycle pulse: stop bit sampled 0, frame discarded
//  overrun      out  1  1-cycle pulse: frame completed while buffer full, new dropped
//  busy         out  1  state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, disarmed; data_out=0, data_valid=0, framing_err=0,
//   overrun=0, busy=0; both synchroniser flops=1. Reset mid-frame aborts it, no flags.
//  serial_in passes 2-flop synchroniser -> rx_s; all decisions use rx_s.
//  FSM: IDLE, START, DATA, PARITY, STOP. Counters: clk_cnt, bit_cnt.
//  IDLE: armed once rx_s seen 1; armed && rx_s==0 -> START, clk_cnt=0.
//  START: at clk_cnt==CLKS_PER_BIT/2-1 sample rx_s; 1 -> IDLE (glitch, no flag);
//   0 -> DATA, clk_cnt=0, bit_cnt=0.
//  DATA: sample at clk_cnt==CLKS_PER_BIT-1 (bit mid); shift into shreg LSB first;
//   after bit_cnt==DATA_BITS-1 sampled -> PARITY.
//  PARITY: sample once at bit mid, store as bit N-1 -> STOP.
//  STOP: sample at bit mid. 1 -> frame complete; 0 -> framing_err pulse, discard,
//   IDLE disarmed (re-arms on rx_s==1, so a held-low line gives one error only).
//   Either way -> IDLE the same cycle.
//  Output buffer (one word): on frame complete, data_out/data_valid update next
//   cycle (latency 1 clk after stop sample).
//   !data_valid, or data_valid&&data_ready that cycle -> load new, data_valid=1.
//   data_valid&&!data_ready -> keep old word, overrun pulses 1 cycle.
//   data_valid&&data_ready, no new frame -> data_valid=0; data_out holds value.
//  data_out stable while data_valid=1 and not yet accepted.
//  Receiver keeps receiving regardless of buffer state (no backpressure on line).
//  Parity never checked here; even-parity frames pass unchanged.
//  Counters sized $clog2(CLKS_PER_BIT), $clog2(DATA_BITS); no wrap beyond limits.
// TESTING (CLKS_PER_BIT=16, DATA_BITS=8, data_ready=1 unless noted)
//  1 send 0xA5 parity 1, stop 1 -> data_out=9'h1A5, data_valid 1 clk after stop
//    mid-sample; no flags.
//  2 send 0x00 parity 0 (bad parity) -> data_out=9'h000 delivered, no flag here;
//    downstream checker error_out=1.
//  3 send 0x3C, stop=0 -> framing_err 1-cycle pulse, data_valid stays 0; line
//    held low 200 clks -> no second pulse; next good frame 0x81/p1 -> 9'h181.
//  4 data_ready=0; frames 0x11/p1 then 0x22/p1 -> data_out=9'h111 kept, overrun
//    pulse at 2nd completion; raise ready -> accepted, data_valid=0.
//  5 low glitch of 4 clks in IDLE -> no START, busy drops back, no output/flags.
//  6 rst asserted during DATA bit 4 -> all outputs 0 immediately; after release
//    full frame 0xFF/p1 -> 9'h1FF.

Source files
------------

// File: rtl/odd_parity_serial_rx.sv
// Bit-serial frame receiver: start, DATA_BITS data (LSB first), parity, stop.
// Hands {parity,data} to a one-word valid/ready buffer; framing and overrun flagged, parity not judged.
module odd_parity_serial_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  output logic [DATA_BITS:0]   data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 framing_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        clk_cnt, clk_cnt_nxt;
  logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] data_sh, data_nxt;
  logic                 par_q, par_nxt;
  logic                 armed, armed_nxt;
  logic                 sync_a, rx_s;
  logic                 frame_ok, frame_bad, done_q;
  logic                 mid_bit;

  // Synchroniser resets to the idle level so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_a <= serial_in;
      rx_s   <= sync_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      data_sh <= '0;
      par_q   <= 1'b0;
      armed   <= 1'b0;
    end else begin
      state   <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      data_sh <= data_nxt;
      par_q   <= par_nxt;
      armed   <= armed_nxt;
    end
  end

  assign mid_bit = (clk_cnt == BIT_LAST);

  always_comb begin
    state_nxt   = state;
    clk_cnt_nxt = clk_cnt;
    bit_cnt_nxt = bit_cnt;
    data_nxt    = data_sh;
    par_nxt     = par_q;
    armed_nxt   = armed;
    frame_ok    = 1'b0;
    frame_bad   = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (rx_s) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          state_nxt = START;
        end
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt = '0;
          if (rx_s) begin
            state_nxt = IDLE;
          end else begin
            state_nxt   = DATA;
            bit_cnt_nxt = '0;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (mid_bit) begin
          clk_cnt_nxt = '0;
          data_nxt    = (data_sh >> 1) | (DATA_BITS'(rx_s) << (DATA_BITS - 1));
          if (bit_cnt == DATA_LAST) begin
            state_nxt = PARITY;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (mid_bit) begin
          clk_cnt_nxt = '0;
          par_nxt     = rx_s;
          state_nxt   = STOP;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        if (mid_bit) begin
          clk_cnt_nxt = '0;
          state_nxt   = IDLE;
          if (rx_s) begin
            frame_ok = 1'b1;
          end else begin
            // Disarm so a line stuck low reports a single framing error.
            frame_bad = 1'b1;
            armed_nxt = 1'b0;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      done_q      <= frame_ok;
      framing_err <= frame_bad;
    end
  end

  // par_q/data_sh stay untouched until the next frame's data phase, so done_q can use them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done_q) begin
        if (!data_valid || data_ready) begin
          data_out   <= {par_q, data_sh};
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
